// File: rtl/riscv_imem_loader_pkg.sv
// Shared definitions for the imem loader: state encoding, byte-index width and
// small state-classification helpers used to derive the registered outputs.
package riscv_imem_loader_pkg;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned BYTE_IDX_W = 2;
   localparam int unsigned PACK_W     = 32;

   typedef enum logic [2:0] {
      LDR_IDLE  = 3'd0,
      LDR_LEN   = 3'd1,
      LDR_DATA  = 3'd2,
      LDR_WRITE = 3'd3,
      LDR_DONE  = 3'd4,
      LDR_ERR   = 3'd5,
      LDR_CHK   = 3'd6
   } ldr_state_e;

   // States in which the byte stream is open
   function automatic logic ldr_takes_bytes(input ldr_state_e s);
      return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_CHK);
   endfunction

   // States that make up an in-progress load
   function automatic logic ldr_is_busy(input ldr_state_e s);
      return (s == LDR_LEN) || (s == LDR_DATA) || (s == LDR_WRITE) || (s == LDR_CHK);
   endfunction

endpackage

// File: rtl/riscv_imem_loader_if.sv
// Byte-stream input and imem write-port bundle of the loader.
//   i_byte_valid/i_byte_data/o_byte_ready : host byte stream
//   o_imem_wr_en/o_imem_wr_addr/o_imem_wr_data : imem write port (word address)
// master: the loader side; slave: the host / memory side.
interface riscv_imem_loader_if #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned IMEM_ADDR_BIT = 12
);
   logic                     i_byte_valid;
   logic [7:0]               i_byte_data;
   logic                     o_byte_ready;
   logic                     o_imem_wr_en;
   logic [IMEM_ADDR_BIT-3:0] o_imem_wr_addr;
   logic [XLEN-1:0]          o_imem_wr_data;

   modport master (
      input  i_byte_valid, i_byte_data,
      output o_byte_ready, o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data
   );

   modport slave (
      output i_byte_valid, i_byte_data,
      input  o_byte_ready, o_imem_wr_en, o_imem_wr_addr, o_imem_wr_data
   );
endinterface

// File: rtl/riscv_byte_packer.sv
// Little-endian 4-byte assembler. The first accepted byte lands in bits [7:0].
//   clk, rst_n     : clock, async active-low reset
//   i_clr          : restart at byte index 0
//   i_byte_en      : byte accepted this cycle
//   i_byte_data    : byte value
//   o_word_c       : assembled word, valid when o_word_done_c is high
//   o_word_done_c  : the 4th byte of a word is being accepted this cycle
module riscv_byte_packer
   import riscv_imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_byte_en,
   input  logic [BYTE_W-1:0] i_byte_data,
   output logic [PACK_W-1:0] o_word_c,
   output logic              o_word_done_c
);

   localparam int unsigned ACC_W = PACK_W - BYTE_W;

   logic [BYTE_IDX_W-1:0] idx_q, idx_d;
   logic [ACC_W-1:0]      acc_q, acc_d;

   // Lower three bytes come from the shift register, the top byte is the live one
   assign o_word_c      = {i_byte_data, acc_q};
   assign o_word_done_c = i_byte_en && (idx_q == BYTE_IDX_W'(3));

   // Shift new bytes in from the top so the oldest ends up in the low byte
   always_comb begin
      idx_d = idx_q;
      acc_d = acc_q;
      if (i_clr) begin
         idx_d = '0;
         acc_d = '0;
      end else if (i_byte_en) begin
         idx_d = idx_q + BYTE_IDX_W'(1);
         acc_d = {i_byte_data, acc_q[ACC_W-1:BYTE_W]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         acc_q <= '0;
      end else begin
         idx_q <= idx_d;
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/riscv_imem_loader.sv
// Instruction-memory loader: receives a 4-byte word count N followed by N
// little-endian words, writes them to imem at word addresses 0..N-1 and holds
// the core in reset until the load completes.
//   i_clk, i_rstn  : clock, async active-low reset
//   i_load_start   : start pulse (honoured in IDLE, DONE, ERR)
//   bus            : byte stream in, imem write port out
//   o_core_rstn    : core reset, released only in DONE
//   o_busy/o_done/o_err : load status (done/err sticky until next start)
// Build option RISCV_IMEM_LOADER_CHKSUM_EN adds a trailing XOR checksum byte.
module riscv_imem_loader
   import riscv_imem_loader_pkg::*;
#(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned IMEM_ADDR_BIT = 12
) (
   input  logic                        i_clk,
   input  logic                        i_rstn,
   input  logic                        i_load_start,
   riscv_imem_loader_if.master         bus,
   output logic                        o_core_rstn,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_err
);

   localparam int unsigned ADDR_W = IMEM_ADDR_BIT - 2;
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [XLEN-1:0] DEPTH = XLEN'(1) << ADDR_W;

`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
   localparam ldr_state_e LDR_FIN = LDR_CHK;
`else
   localparam ldr_state_e LDR_FIN = LDR_DONE;
`endif

   ldr_state_e          state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wr_data_q, wr_data_d;
   logic                ready_q, ready_d;
   logic                wr_en_q, wr_en_d;
   logic                core_rstn_q, core_rstn_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
   logic [BYTE_W-1:0]   chk_q, chk_d;
`endif

   logic                accept_c;
   logic                pk_clr_c;
   logic                pk_en_c;
   logic [PACK_W-1:0]   word_c;
   logic                word_done_c;

   assign accept_c = bus.i_byte_valid && ready_q;
   assign pk_en_c  = accept_c && ((state_q == LDR_LEN) || (state_q == LDR_DATA));

   riscv_byte_packer u_packer (
      .clk           (i_clk),
      .rst_n         (i_rstn),
      .i_clr         (pk_clr_c),
      .i_byte_en     (pk_en_c),
      .i_byte_data   (bus.i_byte_data),
      .o_word_c      (word_c),
      .o_word_done_c (word_done_c)
   );

   // Next state, counters, and registered outputs derived from the next state
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      pk_clr_c  = 1'b0;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
      chk_d     = chk_q;
`endif

      case (state_q)
         LDR_IDLE, LDR_DONE, LDR_ERR: begin
            if (i_load_start) begin
               state_d  = LDR_LEN;
               n_d      = '0;
               cnt_d    = '0;
               addr_d   = '0;
               pk_clr_c = 1'b1;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
               chk_d    = '0;
`endif
            end
         end
         LDR_LEN: begin
            if (word_done_c) begin
               n_d = CNT_W'(word_c);
               if (word_c == '0)        state_d = LDR_FIN;
               else if (word_c > DEPTH) state_d = LDR_ERR;
               else                     state_d = LDR_DATA;
            end
         end
         LDR_DATA: begin
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
            if (accept_c) chk_d = chk_q ^ bus.i_byte_data;
`endif
            if (word_done_c) begin
               wr_data_d = word_c;
               state_d   = LDR_WRITE;
            end
         end
         LDR_WRITE: begin
            // Address and data stay put during the strobe; advance afterwards
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == n_q) ? LDR_FIN : LDR_DATA;
         end
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
         LDR_CHK: begin
            if (accept_c) state_d = (bus.i_byte_data == chk_q) ? LDR_DONE : LDR_ERR;
         end
`endif
         default: state_d = LDR_IDLE;
      endcase

      ready_d     = ldr_takes_bytes(state_d);
      wr_en_d     = (state_d == LDR_WRITE);
      core_rstn_d = (state_d == LDR_DONE);
      busy_d      = ldr_is_busy(state_d);
      done_d      = (state_d == LDR_DONE);
      err_d       = (state_d == LDR_ERR);
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q     <= LDR_IDLE;
         n_q         <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         ready_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         core_rstn_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
         chk_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         ready_q     <= ready_d;
         wr_en_q     <= wr_en_d;
         core_rstn_q <= core_rstn_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
         chk_q       <= chk_d;
`endif
      end
   end

   assign bus.o_byte_ready   = ready_q;
   assign bus.o_imem_wr_en   = wr_en_q;
   assign bus.o_imem_wr_addr = addr_q;
   assign bus.o_imem_wr_data = wr_data_q;
   assign o_core_rstn        = core_rstn_q;
   assign o_busy             = busy_q;
   assign o_done             = done_q;
   assign o_err              = err_q;

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for riscv_imem_loader: drives the byte stream, records imem
// writes and compares them, plus status outputs, against hand-derived values.
module tb_riscv_imem_loader;

   localparam int unsigned AW = 12;
   localparam int unsigned D  = 1 << (AW - 2);

   logic clk        = 1'b0;
   logic rst_n      = 1'b0;
   logic load_start = 1'b0;
   logic core_rstn, busy, done, err;

   riscv_imem_loader_if #(.XLEN(32), .IMEM_ADDR_BIT(AW)) bus ();

   riscv_imem_loader #(.XLEN(32), .IMEM_ADDR_BIT(AW)) dut (
      .i_clk        (clk),
      .i_rstn       (rst_n),
      .i_load_start (load_start),
      .bus          (bus),
      .o_core_rstn  (core_rstn),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err)
   );

   always #5 clk = ~clk;

   int n_checks  = 0;
   int n_errors  = 0;
   int ready_bad = 0;
   logic [31:0] wd[$];
   logic [31:0] wa[$];

   // Record every write strobe; ready must be low whenever the strobe is high
   always @(negedge clk) begin
      if (bus.o_imem_wr_en) begin
         wd.push_back(bus.o_imem_wr_data);
         wa.push_back(32'(bus.o_imem_wr_addr));
         if (bus.o_byte_ready) ready_bad++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a byte until accepted; gap>0 drops valid for that many cycles after
   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      bus.i_byte_valid = 1'b1;
      bus.i_byte_data  = b;
      while (!bus.o_byte_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) begin
         check("byte_accept_timeout", 32'(n), 32'(0));
         bus.i_byte_valid = 1'b0;
         return;
      end
      tick();
      if (gap > 0) begin
         bus.i_byte_valid = 1'b0;
         repeat (gap) tick();
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   function automatic logic [7:0] xor_bytes(input logic [31:0] w);
      return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
   endfunction

   // Trailer byte only exists in the checksum build
   task automatic send_trailer(input logic [7:0] c);
`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
      send_byte(c, 1);
`else
      if (c == 8'hxx) tick();
`endif
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},  32'(bus.o_byte_ready),   32'd0);
      check({tag, "_wr_en"},  32'(bus.o_imem_wr_en),   32'd0);
      check({tag, "_addr"},   32'(bus.o_imem_wr_addr), 32'd0);
      check({tag, "_data"},   bus.o_imem_wr_data,      32'd0);
      check({tag, "_core"},   32'(core_rstn),          32'd0);
      check({tag, "_busy"},   32'(busy),               32'd0);
      check({tag, "_done"},   32'(done),               32'd0);
      check({tag, "_err"},    32'(err),                32'd0);
   endtask

   // Two-word program used by several cases
   task automatic check_basic_writes(input string tag);
      check({tag, "_nwr"}, 32'(wa.size()), 32'd2);
      if (wa.size() == 2) begin
         check({tag, "_a0"}, wa[0], 32'd0);
         check({tag, "_d0"}, wd[0], 32'hDEADBEEF);
         check({tag, "_a1"}, wa[1], 32'd1);
         check({tag, "_d1"}, wd[1], 32'h12345678);
      end
   endtask

   localparam logic [7:0] BASIC_CHK = 8'h2A;

   initial begin
      logic [7:0] bytes[12];
      logic [7:0] acc;

      bus.i_byte_valid = 1'b0;
      bus.i_byte_data  = 8'h00;

      // Reset state
      #12;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();

      // Basic load with exact write/done timing
      pulse_start();
      check("basic_busy", 32'(busy), 32'd1);
      check("basic_ready", 32'(bus.o_byte_ready), 32'd1);
      send_word(32'd2, 1);
      send_word(32'hDEADBEEF, 1);
      for (int i = 0; i < 3; i++) send_byte(8'h78 >> 0 == 8'h78 ? (i == 0 ? 8'h78 : (i == 1 ? 8'h56 : 8'h34)) : 8'h00, 1);
      send_byte(8'h12, 0);
      check("basic_wr_en", 32'(bus.o_imem_wr_en), 32'd1);
      check("basic_wr_addr", 32'(bus.o_imem_wr_addr), 32'd1);
      check("basic_wr_data", bus.o_imem_wr_data, 32'h12345678);
      check("basic_ready_wr", 32'(bus.o_byte_ready), 32'd0);
      bus.i_byte_valid = 1'b0;
      tick();
`ifndef RISCV_IMEM_LOADER_CHKSUM_EN
      check("basic_done_next", 32'(done), 32'd1);
      check("basic_core_next", 32'(core_rstn), 32'd1);
`endif
      send_trailer(BASIC_CHK);
      check("basic_done", 32'(done), 32'd1);
      check("basic_core", 32'(core_rstn), 32'd1);
      check("basic_busy_end", 32'(busy), 32'd0);
      check("basic_ready_end", 32'(bus.o_byte_ready), 32'd0);
      check_basic_writes("basic");

      // N = 0: no writes, done again after start clears it
      wa.delete(); wd.delete();
      pulse_start();
      check("n0_done_clr", 32'(done), 32'd0);
      check("n0_core_held", 32'(core_rstn), 32'd0);
      send_word(32'd0, 1);
      send_trailer(8'h00);
      check("n0_done", 32'(done), 32'd1);
      check("n0_err", 32'(err), 32'd0);
      check("n0_nwr", 32'(wa.size()), 32'd0);

      // N = D+1 is rejected; bytes are refused in ERR
      pulse_start();
      send_word(32'(D + 1), 1);
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_core", 32'(core_rstn), 32'd0);
      check("ovf_ready", 32'(bus.o_byte_ready), 32'd0);
      check("ovf_done", 32'(done), 32'd0);
      bus.i_byte_valid = 1'b1;
      bus.i_byte_data  = 8'h55;
      repeat (3) tick();
      check("err_ready_held", 32'(bus.o_byte_ready), 32'd0);
      check("err_sticky", 32'(err), 32'd1);
      bus.i_byte_valid = 1'b0;
      check("ovf_nwr", 32'(wa.size()), 32'd0);

      // Recovery with N = 1
      pulse_start();
      check("rec_err_clr", 32'(err), 32'd0);
      send_word(32'd1, 1);
      send_word(32'hCAFEF00D, 1);
      send_trailer(8'hC9);
      check("rec_done", 32'(done), 32'd1);
      check("rec_nwr", 32'(wa.size()), 32'd1);
      if (wa.size() == 1) begin
         check("rec_a0", wa[0], 32'd0);
         check("rec_d0", wd[0], 32'hCAFEF00D);
      end

      // Random gaps, valid held through each WRITE cycle
      wa.delete(); wd.delete();
      bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
                8'h00, 8'h00, 8'h00, 8'h00};
      pulse_start();
      send_word(32'd2, 0);
      for (int i = 0; i < 8; i++)
         send_byte(bytes[i], ((i % 4) == 3) ? 0 : int'($urandom_range(0, 3)));
      bus.i_byte_valid = 1'b0;
      tick();
      send_trailer(BASIC_CHK);
      check("gap_done", 32'(done), 32'd1);
      check("gap_ready_on_wr", 32'(ready_bad), 32'd0);
      check_basic_writes("gap");

      // Start pulse during DATA is ignored
      wa.delete(); wd.delete();
      pulse_start();
      send_word(32'd2, 1);
      send_byte(8'hEF, 1);
      send_byte(8'hBE, 1);
      pulse_start();
      check("mid_start_busy", 32'(busy), 32'd1);
      send_byte(8'hAD, 1);
      send_byte(8'hDE, 1);
      send_word(32'h12345678, 1);
      send_trailer(BASIC_CHK);
      check("mid_start_done", 32'(done), 32'd1);
      check_basic_writes("mid_start");

      // Async reset after 5 data bytes, then a clean load from address 0
      pulse_start();
      send_word(32'd2, 1);
      for (int i = 0; i < 5; i++) send_byte(bytes[i], 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      tick();
      #3;
      rst_n = 1'b1;
      tick();
      wa.delete(); wd.delete();
      pulse_start();
      send_word(32'd2, 1);
      send_word(32'hDEADBEEF, 1);
      send_word(32'h12345678, 1);
      send_trailer(BASIC_CHK);
      check("post_rst_done", 32'(done), 32'd1);
      check_basic_writes("post_rst");

      // Full depth N = D writes 0..D-1
      wa.delete(); wd.delete();
      acc = 8'h00;
      pulse_start();
      send_word(32'(D), 0);
      for (int i = 0; i < int'(D); i++) begin
         send_word(32'(i) ^ 32'hA5000000, 0);
         acc = acc ^ xor_bytes(32'(i) ^ 32'hA5000000);
      end
      bus.i_byte_valid = 1'b0;
      tick();
      send_trailer(acc);
      check("full_done", 32'(done), 32'd1);
      check("full_nwr", 32'(wa.size()), 32'(D));
      if (wa.size() == D) begin
         check("full_a_last", wa[D-1], 32'(D - 1));
         check("full_d_last", wd[D-1], 32'(D - 1) ^ 32'hA5000000);
         check("full_a_mid", wa[300], 32'd300);
      end
      check("full_ready_on_wr", 32'(ready_bad), 32'd0);

`ifdef RISCV_IMEM_LOADER_CHKSUM_EN
      // Wrong trailer ends in ERR
      pulse_start();
      send_word(32'd2, 1);
      send_word(32'hDEADBEEF, 1);
      send_word(32'h12345678, 1);
      send_trailer(BASIC_CHK ^ 8'h01);
      check("chk_bad_err", 32'(err), 32'd1);
      check("chk_bad_done", 32'(done), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
